// File: rtl/dmem_pkg.sv
// Shared encodings for the byte-lane data memory: access sizes, FSM states
// and the base byte-enable patterns that are shifted into place by offset.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic {
        CLEAR,
        RUN
    } state_e;

    localparam logic [3:0] LANES_NONE = 4'b0000;
    localparam logic [3:0] LANES_BYTE = 4'b0001;
    localparam logic [3:0] LANES_HALF = 4'b0011;
    localparam logic [3:0] LANES_WORD = 4'b1111;

endpackage

// File: rtl/dmem_bytelane_if.sv
// Request/response bundle between the MEM stage (master) and the data memory (slave).
interface dmem_bytelane_if;

    logic        i_req;
    logic        i_we;
    logic [1:0]  i_size;
    logic        i_unsigned;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic        o_ready;
    logic        o_rvalid;
    logic [31:0] o_data;
    logic        o_fault;

    modport master (
        output i_req, i_we, i_size, i_unsigned, i_addr, i_data,
        input  o_ready, o_rvalid, o_data, o_fault
    );

    modport slave (
        input  i_req, i_we, i_size, i_unsigned, i_addr, i_data,
        output o_ready, o_rvalid, o_data, o_fault
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store data replicated across lanes with a byte
// enable, and load data picked from its lane then sign/zero extended.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    input  logic        i_unsigned,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Misaligned offsets may shift enables off the word; the fault check gates those writes.
    always_comb begin
        o_be    = LANES_NONE;
        o_wdata = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_be    = LANES_BYTE << i_offset;
                o_wdata = {4{i_wdata[7:0]}};
            end
            SZ_HALF: begin
                o_be    = LANES_HALF << i_offset;
                o_wdata = {2{i_wdata[15:0]}};
            end
            SZ_WORD: o_be = LANES_WORD;
            default: o_be = LANES_NONE;
        endcase
    end

    always_comb begin
        byte_sel = i_rword[8*i_offset +: 8];
        half_sel = i_offset[1] ? i_rword[31:16] : i_rword[15:0];
        case (i_size)
            SZ_BYTE: o_rdata = i_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: o_rdata = i_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: o_rdata = i_rword;
        endcase
    end

endmodule

// File: rtl/dmem_bytelane.sv
// Parametrised MEM-stage data memory: byte/half/word access with 1-cycle
// registered response, fault reporting and a hardware clear after reset.
module dmem_bytelane
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS    = 256,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    dmem_bytelane_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            rvalid_q, rvalid_d;
    logic [31:0]     data_q, data_d;
    logic            fault_q, fault_d;

    logic [31:0]     mem_array [DEPTH_WORDS];

    logic [AW-1:0]   idx;
    logic [1:0]      offset;
    logic            hi_set;
    logic            fault;
    logic            accept;
    logic            store_we;
    logic            clear_we;
    logic [31:0]     rword;
    logic [3:0]      be;
    logic [31:0]     wdata_rep;
    logic [31:0]     rdata_ext;

    assign idx    = bus.i_addr[AW+1:2];
    assign offset = bus.i_addr[1:0];
    assign hi_set = (bus.i_addr >> (AW + 2)) != 32'h0;
    assign accept = bus.i_req && (state_q == RUN);
    assign rword  = mem_array[idx];

    always_comb begin
        fault = 1'b0;
        if (bus.i_size == SZ_RSVD)                         fault = 1'b1;
        else if (hi_set)                                   fault = 1'b1;
        else if ((bus.i_size == SZ_HALF) && offset[0])     fault = 1'b1;
        else if ((bus.i_size == SZ_WORD) && (offset != 2'b00)) fault = 1'b1;
    end

    dmem_lane_align u_align (
        .i_size     (bus.i_size),
        .i_offset   (offset),
        .i_wdata    (bus.i_data),
        .i_unsigned (bus.i_unsigned),
        .i_rword    (rword),
        .o_be       (be),
        .o_wdata    (wdata_rep),
        .o_rdata    (rdata_ext)
    );

    assign store_we = accept && bus.i_we && !fault;
    // Held off during reset so the array only ever changes through clearing or stores.
    assign clear_we = CLEAR_ON_RESET && (state_q == CLEAR) && i_rst_n;

    always_ff @(posedge i_clk) begin
        if (clear_we) begin
            mem_array[cnt_q] <= 32'h0;
        end else if (store_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_array[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rvalid_d = 1'b0;
        data_d   = 32'h0;
        fault_d  = 1'b0;
        case (state_q)
            CLEAR: begin
                if (CLEAR_ON_RESET) begin
                    cnt_d = cnt_q + AW'(1);
                    if (cnt_q == AW'(DEPTH_WORDS - 1)) state_d = RUN;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    rvalid_d = 1'b1;
                    fault_d  = fault;
                    data_d   = (bus.i_we || fault) ? 32'h0 : rdata_ext;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= CLEAR;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            data_q   <= 32'h0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            data_q   <= data_d;
            fault_q  <= fault_d;
        end
    end

    assign bus.o_ready  = (state_q == RUN);
    assign bus.o_rvalid = rvalid_q;
    assign bus.o_data   = data_q;
    assign bus.o_fault  = fault_q;

endmodule

// File: tb/tb_dmem_bytelane.sv
// Scoreboard bench for dmem_bytelane: a cleared 256-word instance and a
// 16-word instance with clearing disabled.
module tb_dmem_bytelane;

    typedef struct {
        string       name;
        logic        req;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_d;
        logic        exp_f;
    } acc_t;

    typedef struct {
        logic [31:0] d;
        logic        f;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_b_n;
    int   vectors = 0;
    int   miscompares = 0;
    rsp_t sb[$];

    always #5 clk = ~clk;

    dmem_bytelane_if bus ();
    dmem_bytelane_if bus_b ();

    dmem_bytelane #(.DEPTH_WORDS(256), .CLEAR_ON_RESET(1'b1)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    dmem_bytelane #(.DEPTH_WORDS(16), .CLEAR_ON_RESET(1'b0)) dut_nc (
        .i_clk   (clk),
        .i_rst_n (rst_b_n),
        .bus     (bus_b)
    );

    function automatic acc_t mk(string n, logic req, logic we, logic [1:0] size, logic uns,
                                logic [31:0] addr, logic [31:0] data, logic [31:0] exp_d, logic exp_f);
        acc_t a;
        a.name = n; a.req = req; a.we = we; a.size = size; a.uns = uns;
        a.addr = addr; a.data = data; a.exp_d = exp_d; a.exp_f = exp_f;
        return a;
    endfunction

    // Drives one cycle on the main instance and queues the response it must produce.
    task automatic drive(input acc_t a);
        bus.i_req      = a.req;
        bus.i_we       = a.we;
        bus.i_size     = a.size;
        bus.i_unsigned = a.uns;
        bus.i_addr     = a.addr;
        bus.i_data     = a.data;
        if (a.req) sb.push_back('{a.exp_d, a.exp_f});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int edges;
        int spurious;
        rst_n = 1'b0;
        bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_size = 2'b10; bus.i_unsigned = 1'b0;
        bus.i_addr = 32'h0; bus.i_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (bus.o_ready !== 1'b0 || bus.o_rvalid !== 1'b0 || bus.o_data !== 32'h0 || bus.o_fault !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: ready=%b rvalid=%b data=%h fault=%b, want 0 0 00000000 0",
                     bus.o_ready, bus.o_rvalid, bus.o_data, bus.o_fault);
        end
        // Request held high throughout the clear must be ignored.
        bus.i_req = 1'b1;
        rst_n = 1'b1;
        edges = 0;
        spurious = 0;
        while (edges < 1000) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.o_rvalid !== 1'b0) spurious++;
            if (bus.o_ready === 1'b1) break;
        end
        bus.i_req = 1'b0;
        vectors++;
        if (edges != 256) begin
            miscompares++;
            $display("FAIL clear_duration: ready after %0d edges, want 256", edges);
        end
        vectors++;
        if (spurious != 0) begin
            miscompares++;
            $display("FAIL req_during_clear: %0d responses, want 0", spurious);
        end
    endtask

    task automatic test_store_load();
        acc_t t[$];
        rsp_t e;
        t.push_back(mk("lw_last_cleared", 1, 0, 2'b10, 0, 32'h3FC, 32'h0,        32'h00000000, 0));
        t.push_back(mk("sw_deadbeef",     1, 1, 2'b10, 0, 32'h010, 32'hDEADBEEF, 32'h00000000, 0));
        t.push_back(mk("lw_b2b",          1, 0, 2'b10, 0, 32'h010, 32'h0,        32'hDEADBEEF, 0));
        t.push_back(mk("sb_80",           1, 1, 2'b00, 0, 32'h013, 32'h12345680, 32'h00000000, 0));
        t.push_back(mk("lb_neg",          1, 0, 2'b00, 0, 32'h013, 32'h0,        32'hFFFFFF80, 0));
        t.push_back(mk("lbu",             1, 0, 2'b00, 1, 32'h013, 32'h0,        32'h00000080, 0));
        t.push_back(mk("lw_after_sb",     1, 0, 2'b10, 0, 32'h010, 32'h0,        32'h80ADBEEF, 0));
        t.push_back(mk("idle",            0, 0, 2'b10, 0, 32'h010, 32'h0,        32'h00000000, 0));
        t.push_back(mk("sh_a5f0",         1, 1, 2'b01, 0, 32'h022, 32'h9999A5F0, 32'h00000000, 0));
        t.push_back(mk("lh_neg",          1, 0, 2'b01, 0, 32'h022, 32'h0,        32'hFFFFA5F0, 0));
        t.push_back(mk("lhu",             1, 0, 2'b01, 1, 32'h022, 32'h0,        32'h0000A5F0, 0));
        t.push_back(mk("lw_after_sh",     1, 0, 2'b10, 0, 32'h020, 32'h0,        32'hA5F00000, 0));
        t.push_back(mk("sb_7f",           1, 1, 2'b00, 0, 32'h021, 32'h0000007F, 32'h00000000, 0));
        t.push_back(mk("lb_pos",          1, 0, 2'b00, 0, 32'h021, 32'h0,        32'h0000007F, 0));
        t.push_back(mk("lw_lanes_kept",   1, 0, 2'b10, 0, 32'h020, 32'h0,        32'hA5F07F00, 0));
        t.push_back(mk("lh_low",          1, 0, 2'b01, 0, 32'h010, 32'h0,        32'hFFFFBEEF, 0));
        t.push_back(mk("lbu_lane0",       1, 0, 2'b00, 1, 32'h010, 32'h0,        32'h000000EF, 0));
        t.push_back(mk("lb_lane2",        1, 0, 2'b00, 0, 32'h012, 32'h0,        32'hFFFFFFAD, 0));
        t.push_back(mk("lw_uns_ignored",  1, 0, 2'b10, 1, 32'h010, 32'h0,        32'h80ADBEEF, 0));
        foreach (t[i]) begin
            drive(t[i]);
            vectors++;
            if (t[i].req) begin
                e = sb.pop_front();
                if (bus.o_rvalid !== 1'b1 || bus.o_data !== e.d || bus.o_fault !== e.f) begin
                    miscompares++;
                    $display("FAIL %s: rvalid=%b data=%h fault=%b, want rvalid=1 data=%h fault=%b",
                             t[i].name, bus.o_rvalid, bus.o_data, bus.o_fault, e.d, e.f);
                end
            end else if (bus.o_rvalid !== 1'b0) begin
                miscompares++;
                $display("FAIL %s: rvalid=%b, want 0", t[i].name, bus.o_rvalid);
            end
        end
        bus.i_req = 1'b0;
    endtask

    task automatic test_faults();
        acc_t t[$];
        rsp_t e;
        t.push_back(mk("sh_odd",          1, 1, 2'b01, 0, 32'h011, 32'h00001234, 32'h00000000, 1));
        t.push_back(mk("lw_after_sh_odd", 1, 0, 2'b10, 0, 32'h010, 32'h0,        32'h80ADBEEF, 0));
        t.push_back(mk("sw_oor",          1, 1, 2'b10, 0, 32'h400, 32'h11111111, 32'h00000000, 1));
        t.push_back(mk("lw_oor",          1, 0, 2'b10, 0, 32'h400, 32'h0,        32'h00000000, 1));
        t.push_back(mk("lw_no_alias",     1, 0, 2'b10, 0, 32'h000, 32'h0,        32'h00000000, 0));
        t.push_back(mk("st_rsvd_size",    1, 1, 2'b11, 0, 32'h010, 32'hFFFFFFFF, 32'h00000000, 1));
        t.push_back(mk("lw_after_rsvd",   1, 0, 2'b10, 0, 32'h010, 32'h0,        32'h80ADBEEF, 0));
        t.push_back(mk("ld_rsvd_size",    1, 0, 2'b11, 0, 32'h010, 32'h0,        32'h00000000, 1));
        t.push_back(mk("sw_misalign",     1, 1, 2'b10, 0, 32'h012, 32'h55555555, 32'h00000000, 1));
        t.push_back(mk("lh_odd",          1, 0, 2'b01, 0, 32'h013, 32'h0,        32'h00000000, 1));
        t.push_back(mk("lw_misalign",     1, 0, 2'b10, 0, 32'h011, 32'h0,        32'h00000000, 1));
        t.push_back(mk("lh_hi_half",      1, 0, 2'b01, 0, 32'h012, 32'h0,        32'hFFFF80AD, 0));
        t.push_back(mk("sb_top_bit",      1, 1, 2'b00, 0, 32'h80000010, 32'h000000AA, 32'h00000000, 1));
        t.push_back(mk("lw_after_top",    1, 0, 2'b10, 0, 32'h010, 32'h0,        32'h80ADBEEF, 0));
        t.push_back(mk("lbu_last_byte",   1, 0, 2'b00, 1, 32'h3FF, 32'h0,        32'h00000000, 0));
        t.push_back(mk("sb_last_byte",    1, 1, 2'b00, 0, 32'h3FF, 32'h000000AB, 32'h00000000, 0));
        t.push_back(mk("lw_last_word",    1, 0, 2'b10, 0, 32'h3FC, 32'h0,        32'hAB000000, 0));
        foreach (t[i]) begin
            drive(t[i]);
            vectors++;
            e = sb.pop_front();
            if (bus.o_rvalid !== 1'b1 || bus.o_data !== e.d || bus.o_fault !== e.f) begin
                miscompares++;
                $display("FAIL %s: rvalid=%b data=%h fault=%b, want rvalid=1 data=%h fault=%b",
                         t[i].name, bus.o_rvalid, bus.o_data, bus.o_fault, e.d, e.f);
            end
        end
        bus.i_req = 1'b0;
    endtask

    task automatic test_reset_midclear();
        int edges;
        acc_t t[$];
        rsp_t e;
        // Reset while a load response is being presented.
        bus.i_req = 1'b1; bus.i_we = 1'b0; bus.i_size = 2'b10; bus.i_addr = 32'h010;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.i_req = 1'b0;
        #1;
        vectors++;
        if (bus.o_rvalid !== 1'b0 || bus.o_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_access: rvalid=%b ready=%b, want 0 0", bus.o_rvalid, bus.o_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        vectors++;
        if (bus.o_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL still_clearing_at_100: ready=%b, want 0", bus.o_ready);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.o_rvalid !== 1'b0 || bus.o_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_clear: rvalid=%b ready=%b, want 0 0", bus.o_rvalid, bus.o_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        edges = 0;
        while (edges < 1000) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.o_ready === 1'b1) break;
        end
        vectors++;
        if (edges != 256) begin
            miscompares++;
            $display("FAIL restarted_clear: ready after %0d edges, want 256", edges);
        end
        t.push_back(mk("cleared_0x10",  1, 0, 2'b10, 0, 32'h010, 32'h0, 32'h00000000, 0));
        t.push_back(mk("cleared_0x20",  1, 0, 2'b10, 0, 32'h020, 32'h0, 32'h00000000, 0));
        t.push_back(mk("cleared_0x3fc", 1, 0, 2'b10, 0, 32'h3FC, 32'h0, 32'h00000000, 0));
        foreach (t[i]) begin
            drive(t[i]);
            vectors++;
            e = sb.pop_front();
            if (bus.o_rvalid !== 1'b1 || bus.o_data !== e.d || bus.o_fault !== e.f) begin
                miscompares++;
                $display("FAIL %s: rvalid=%b data=%h fault=%b, want rvalid=1 data=%h fault=%b",
                         t[i].name, bus.o_rvalid, bus.o_data, bus.o_fault, e.d, e.f);
            end
        end
        bus.i_req = 1'b0;
    endtask

    task automatic test_no_clear();
        rsp_t e;
        vectors++;
        if (bus_b.o_ready !== 1'b0 || bus_b.o_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL nc_reset_state: ready=%b rvalid=%b, want 0 0", bus_b.o_ready, bus_b.o_rvalid);
        end
        bus_b.i_req = 1'b1; bus_b.i_we = 1'b0; bus_b.i_size = 2'b10; bus_b.i_unsigned = 1'b0;
        bus_b.i_addr = 32'h0; bus_b.i_data = 32'h0;
        rst_b_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (bus_b.o_ready !== 1'b1 || bus_b.o_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL nc_one_edge: ready=%b rvalid=%b, want 1 0", bus_b.o_ready, bus_b.o_rvalid);
        end
        bus_b.i_we = 1'b1; bus_b.i_addr = 32'h004; bus_b.i_data = 32'hCAFEF00D;
        sb.push_back('{32'h0, 1'b0});
        @(posedge clk);
        #1;
        vectors++;
        e = sb.pop_front();
        if (bus_b.o_rvalid !== 1'b1 || bus_b.o_data !== e.d || bus_b.o_fault !== e.f) begin
            miscompares++;
            $display("FAIL nc_sw: rvalid=%b data=%h fault=%b, want 1 %h %b",
                     bus_b.o_rvalid, bus_b.o_data, bus_b.o_fault, e.d, e.f);
        end
        bus_b.i_we = 1'b0;
        sb.push_back('{32'hCAFEF00D, 1'b0});
        @(posedge clk);
        #1;
        vectors++;
        e = sb.pop_front();
        if (bus_b.o_rvalid !== 1'b1 || bus_b.o_data !== e.d || bus_b.o_fault !== e.f) begin
            miscompares++;
            $display("FAIL nc_lw: rvalid=%b data=%h fault=%b, want 1 %h %b",
                     bus_b.o_rvalid, bus_b.o_data, bus_b.o_fault, e.d, e.f);
        end
        bus_b.i_addr = 32'h040;
        sb.push_back('{32'h0, 1'b1});
        @(posedge clk);
        #1;
        vectors++;
        e = sb.pop_front();
        if (bus_b.o_rvalid !== 1'b1 || bus_b.o_data !== e.d || bus_b.o_fault !== e.f) begin
            miscompares++;
            $display("FAIL nc_oor: rvalid=%b data=%h fault=%b, want 1 %h %b",
                     bus_b.o_rvalid, bus_b.o_data, bus_b.o_fault, e.d, e.f);
        end
        bus_b.i_req = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (bus_b.o_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL nc_idle: rvalid=%b, want 0", bus_b.o_rvalid);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_b_n = 1'b0;
        bus_b.i_req = 1'b0; bus_b.i_we = 1'b0; bus_b.i_size = 2'b00; bus_b.i_unsigned = 1'b0;
        bus_b.i_addr = 32'h0; bus_b.i_data = 32'h0;
        test_reset();
        test_store_load();
        test_faults();
        test_reset_midclear();
        test_no_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_bytelane.md
# dmem_bytelane

Parametrised data memory for the Harvard pipeline's MEM stage. It replaces the fixed 32-word, word-only, asynchronous-read RAM with four capabilities:
- configurable depth
- RV32 byte/half/word stores and sign/zero-extended loads
- a registered read behind a ready/valid handshake
- fault reporting for misaligned, out-of-range and invalid-size accesses

After reset it clears itself in hardware, so the pipeline never sees stale contents.

## Interface
Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, ≥ 4
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = contents retained and undefined at power-up

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_req  in  1  access request, sampled only when o_ready=1
- i_we  in  1  1 = store, 0 = load
- i_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- i_unsigned  in  1  load only: 1 = zero-extend, 0 = sign-extend
- i_addr  in  32  byte address
- i_data  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- o_ready  out  1  block accepts a request this cycle
- o_rvalid  out  1  one-cycle response strobe for every accepted request
- o_data  out  32  extended load data; 0 for stores and faults
- o_fault  out  1  qualifies o_rvalid; the access was rejected

## Operation
- States: CLEAR and RUN. Reset forces CLEAR, clear counter 0, o_ready=0, o_rvalid=0, o_fault=0, o_data=0.
- CLEAR with CLEAR_ON_RESET=1:
  - each edge writes 0 to word[cnt] and increments cnt
  - after the edge that writes word DEPTH_WORDS-1, go to RUN
- CLEAR with CLEAR_ON_RESET=0: go to RUN on the first edge; no writes.
- RUN: o_ready=1 every cycle. Accepted access = i_req & o_ready.
- Decode:
  - word index = i_addr[log2(DEPTH_WORDS)+1:2]
  - offset = i_addr[1:0]
- Fault, checked in priority order; no aliasing:
  1. i_size=11
  2. any i_addr bit above log2(DEPTH_WORDS)+1 set
  3. half with offset odd
  4. word with offset ≠ 0
- A faulting store writes nothing. A faulting load returns o_data=0.
- Store byte lanes:
  - SB writes lane[offset] with i_data[7:0]
  - SH writes lanes offset and offset+1 with i_data[15:0], little-endian
  - SW writes all four lanes
  - Unwritten lanes are preserved.
- Load: select the byte/half at offset, then extend per i_unsigned. i_unsigned is ignored for word loads.
- Requests while o_ready=0 are dropped silently; they produce no response.

## Timing
- Fixed latency of 1. An access accepted at edge N produces o_rvalid=1, with o_data and o_fault, for the cycle after edge N. All three are registered.
- Throughput is one access per cycle. o_rvalid is low in any cycle following an edge with no accepted access.
- Stores are committed at the accepting edge. A load accepted at the next edge to the same word observes the new bytes.
- Store ack: o_rvalid=1, o_data=0, o_fault=0.
- Clear duration: o_ready rises after DEPTH_WORDS edges (1 edge if CLEAR_ON_RESET=0) following reset release.
- Reset asserted mid-clear or mid-access:
  - immediate return to CLEAR with cnt=0
  - the pending response is discarded (o_rvalid low)
  - the clear restarts from word 0
- Reset never touches the array asynchronously; contents are defined only by clearing or writes.

## Structure
- Package dmem_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - state enum {CLEAR, RUN}
  - lane-mask helper constants
- Sub-module dmem_lane_align, combinational:
  - store side: (size, offset, i_data) → 4-bit byte enable + lane-replicated write data
  - load side: (size, offset, unsigned, raw word) → extended result
- Top level holds the array as four byte-wide lanes or a byte-enabled word, plus the FSM, clear counter and response registers.

## Test plan
- Reset release, CLEAR_ON_RESET=1, DEPTH_WORDS=256 → o_ready rises exactly 256 edges later; LW of addr 0x3FC returns 0x00000000.
- SW 0xDEADBEEF @0x10, next cycle LW @0x10 → o_rvalid the following cycle, o_data=0xDEADBEEF, o_fault=0. Back-to-back with no bubble.
- SB 0x80 @0x13, then:
  - LB @0x13 → 0xFFFFFF80
  - LBU @0x13 → 0x00000080
  - LW @0x10 → 0x80ADBEEF
- Faults: the three accesses below each give o_rvalid=1, o_fault=1, o_data=0. Each is then checked with an LW of the targeted word, which is unchanged.
  - SH @0x11
  - LW @0x400 (DEPTH_WORDS=256)
  - i_size=11
- Reset pulse at clear count 100 → o_rvalid=0, o_ready=0; the clear restarts and o_ready rises 256 edges after release.
- CLEAR_ON_RESET=0: o_ready=1 one edge after release. An i_req issued while o_ready=0 yields no o_rvalid.
